// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared widths, FSM encoding and operand helper for div_unit
package div_unit_pkg;

  localparam int unsigned DIV_W = 32;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // Magnitude of an operand; unsigned operands pass through untouched.
  function automatic logic [DIV_W-1:0] div_mag(input logic is_signed, input logic [DIV_W-1:0] v);
    return (is_signed && v[DIV_W-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - issue/result handshake bundle between EXE and div_unit
interface div_unit_if;
  import div_unit_pkg::*;

  logic             div_in_valid;
  logic             div_in_ready;
  logic             div_signed;
  logic [DIV_W-1:0] div_src1;
  logic [DIV_W-1:0] div_src2;
  logic             div_out_valid;
  logic             div_out_ready;
  logic [DIV_W-1:0] div_quot;
  logic [DIV_W-1:0] div_rem;

  modport master (
    output div_in_valid, div_signed, div_src1, div_src2, div_out_ready,
    input  div_in_ready, div_out_valid, div_quot, div_rem
  );

  modport slave (
    input  div_in_valid, div_signed, div_src1, div_src2, div_out_ready,
    output div_in_ready, div_out_valid, div_quot, div_rem
  );

endinterface

// File: rtl/div_iter.sv
// rtl/div_iter.sv - one combinational radix-2 restoring division step
module div_iter
  import div_unit_pkg::*;
(
  input  logic [DIV_W:0]   partial_rem,
  input  logic [DIV_W-1:0] divisor,
  input  logic             next_bit,
  output logic [DIV_W:0]   new_rem,
  output logic             q_bit
);

  // One spare bit above the 33-bit remainder so the trial sign is never lost.
  logic [DIV_W+1:0] shifted;
  logic [DIV_W+1:0] diff;

  assign shifted = {partial_rem, next_bit};
  assign diff    = shifted - {2'b00, divisor};
  assign q_bit   = ~diff[DIV_W+1];
  assign new_rem = q_bit ? diff[DIV_W:0] : shifted[DIV_W:0];

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle 32-bit DIV.W/MOD.W/DIV.WU/MOD.WU unit with flush
module div_unit
  import div_unit_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      flush,
  div_unit_if.slave dif
);

  localparam logic [CNT_W-1:0] CNT_LAST = '1;

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W:0]   rem_q, rem_d;
  logic [DIV_W-1:0] dvd_q, dvd_d;
  logic [DIV_W-1:0] dvs_q, dvs_d;
  logic [DIV_W-1:0] src1_q, src1_d;
  logic             quot_neg_q, quot_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             dbz_q, dbz_d;

  logic             in_ready;
  logic             accept;
  logic [DIV_W:0]   iter_rem;
  logic             iter_qbit;

  div_iter u_iter (
    .partial_rem (rem_q),
    .divisor     (dvs_q),
    .next_bit    (dvd_q[DIV_W-1]),
    .new_rem     (iter_rem),
    .q_bit       (iter_qbit)
  );

  assign in_ready = (state_q == ST_IDLE) & ~reset;
  assign accept   = dif.div_in_valid & in_ready & ~flush;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    src1_d     = src1_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    dbz_d      = dbz_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          dvd_d      = div_mag(dif.div_signed, dif.div_src1);
          dvs_d      = div_mag(dif.div_signed, dif.div_src2);
          src1_d     = dif.div_src1;
          quot_neg_d = dif.div_signed & (dif.div_src1[DIV_W-1] ^ dif.div_src2[DIV_W-1]);
          rem_neg_d  = dif.div_signed & dif.div_src1[DIV_W-1];
          dbz_d      = (dif.div_src2 == '0);
          cnt_d      = '0;
          rem_d      = '0;
          state_d    = ST_CALC;
        end
      end
      ST_CALC: begin
        // Dividend bits leave at the top while quotient bits enter at the bottom.
        rem_d = iter_rem;
        dvd_d = {dvd_q[DIV_W-2:0], iter_qbit};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (dif.div_out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      src1_q     <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      src1_q     <= src1_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      dbz_q      <= dbz_d;
    end
  end

  // Zero divisor yields all-ones quotient and the untouched dividend as remainder.
  assign dif.div_in_ready  = in_ready;
  assign dif.div_out_valid = (state_q == ST_DONE);
  assign dif.div_quot      = dbz_q ? '1 : (quot_neg_q ? -dvd_q : dvd_q);
  assign dif.div_rem       = dbz_q ? src1_q : (rem_neg_q ? -rem_q[DIV_W-1:0] : rem_q[DIV_W-1:0]);

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - randomized self-checking bench for div_unit against a reference model
module tb_div_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  div_unit_if dif();

  div_unit dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .dif   (dif)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_q(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (b == 32'd0) return 32'hFFFFFFFF;
    if (!s) return a / b;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 32'(sa / sb);
  endfunction

  function automatic logic [31:0] ref_r(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (b == 32'd0) return a;
    if (!s) return a % b;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 32'(sa % sb);
  endfunction

  // Transaction-level model: busy flag plus edges elapsed since accept.
  logic        started = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_zero = 1'b0;
  int          m_age = 0;
  logic [31:0] m_q = '0;
  logic [31:0] m_r = '0;

  always @(posedge clk) begin
    started <= 1'b1;
    if (reset) begin
      m_busy <= 1'b0;
      m_age  <= 0;
      m_zero <= 1'b1;
    end else if (flush) begin
      m_busy <= 1'b0;
    end else if (!m_busy && dif.div_in_valid) begin
      m_busy <= 1'b1;
      m_age  <= 0;
      m_zero <= 1'b0;
      m_q    <= ref_q(dif.div_signed, dif.div_src1, dif.div_src2);
      m_r    <= ref_r(dif.div_signed, dif.div_src1, dif.div_src2);
    end else if (m_busy) begin
      if (m_age == 32) begin
        if (dif.div_out_ready) m_busy <= 1'b0;
      end else begin
        m_age <= m_age + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", {31'd0, dif.div_in_ready}, {31'd0, (!m_busy && !reset)});
      chk("out_valid", {31'd0, dif.div_out_valid}, {31'd0, (m_busy && m_age == 32)});
      if (m_busy && m_age == 32) begin
        chk("quot", dif.div_quot, m_q);
        chk("rem", dif.div_rem, m_r);
      end
      if (m_zero) begin
        chk("reset_quot", dif.div_quot, 32'd0);
        chk("reset_rem", dif.div_rem, 32'd0);
      end
    end
  end

  // Called just after a rising edge with the unit idle; returns just after the result edge.
  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b, input int hold,
                       output logic [31:0] q, output logic [31:0] r, output int lat);
    dif.div_in_valid = 1'b1;
    dif.div_signed   = s;
    dif.div_src1     = a;
    dif.div_src2     = b;
    @(posedge clk) #2;
    dif.div_in_valid = 1'b0;
    dif.div_signed   = 1'($urandom_range(0, 1));
    dif.div_src1     = $urandom;
    dif.div_src2     = $urandom;
    lat = 0;
    q = '0;
    r = '0;
    forever begin
      @(negedge clk);
      lat++;
      if (dif.div_out_valid) break;
      if (lat >= 100) begin
        chk("result_timeout", 32'(lat), 32'd33);
        break;
      end
    end
    q = dif.div_quot;
    r = dif.div_rem;
    repeat (hold) @(negedge clk);
    dif.div_out_ready = 1'b1;
    @(posedge clk) #2;
    dif.div_out_ready = 1'b0;
  endtask

  task automatic watch(input int n, output logic seen);
    seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (dif.div_out_valid) seen = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] q, r, a, b;
    logic        s, seen;
    int          lat, hold;

    dif.div_in_valid  = 1'b0;
    dif.div_signed    = 1'b0;
    dif.div_src1      = '0;
    dif.div_src2      = '0;
    dif.div_out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", {31'd0, dif.div_in_ready}, 32'd1);
    chk("out_valid_after_reset", {31'd0, dif.div_out_valid}, 32'd0);
    @(posedge clk) #2;

    chk("model_sq", ref_q(1'b1, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFD);
    chk("model_sr", ref_r(1'b1, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);
    chk("model_ovf", ref_q(1'b1, 32'h80000000, 32'hFFFFFFFF), 32'h80000000);

    do_op(1'b0, 32'd100, 32'd7, 0, q, r, lat);
    chk("u100_7_lat", 32'(lat), 32'd33);
    chk("u100_7_q", q, 32'd14);
    chk("u100_7_r", r, 32'd2);

    do_op(1'b1, 32'hFFFFFFF9, 32'd2, 0, q, r, lat);
    chk("s_m7_2_q", q, 32'hFFFFFFFD);
    chk("s_m7_2_r", r, 32'hFFFFFFFF);
    chk("s_m7_2_lat", 32'(lat), 32'd33);

    do_op(1'b0, 32'hFFFFFFF9, 32'd2, 0, q, r, lat);
    chk("u_fff9_2_q", q, 32'h7FFFFFFC);
    chk("u_fff9_2_r", r, 32'd1);

    do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, q, r, lat);
    chk("ovf_q", q, 32'h80000000);
    chk("ovf_r", r, 32'd0);

    do_op(1'b1, 32'h87654321, 32'd0, 0, q, r, lat);
    chk("sdz_q", q, 32'hFFFFFFFF);
    chk("sdz_r", r, 32'h87654321);
    chk("sdz_lat", 32'(lat), 32'd33);

    do_op(1'b0, 32'h12345678, 32'd0, 0, q, r, lat);
    chk("udz_q", q, 32'hFFFFFFFF);
    chk("udz_r", r, 32'h12345678);

    do_op(1'b0, 32'd1000, 32'd10, 5, q, r, lat);
    chk("bp_q", q, 32'd100);
    chk("bp_r", r, 32'd0);

    // Flush in the 10th calculation cycle, with a competing issue request.
    dif.div_in_valid = 1'b1;
    dif.div_signed   = 1'b0;
    dif.div_src1     = 32'd55;
    dif.div_src2     = 32'd5;
    @(posedge clk) #2;
    dif.div_in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    flush = 1'b1;
    dif.div_in_valid = 1'b1;
    @(posedge clk) #2;
    flush = 1'b0;
    dif.div_in_valid = 1'b0;
    @(negedge clk);
    chk("flush_in_ready", {31'd0, dif.div_in_ready}, 32'd1);
    watch(40, seen);
    chk("flush_no_result", {31'd0, seen}, 32'd0);
    @(posedge clk) #2;
    do_op(1'b0, 32'd9, 32'd3, 0, q, r, lat);
    chk("post_flush_q", q, 32'd3);
    chk("post_flush_r", r, 32'd0);

    // Reset in the middle of a calculation.
    dif.div_in_valid = 1'b1;
    dif.div_signed   = 1'b1;
    dif.div_src1     = 32'hDEADBEEF;
    dif.div_src2     = 32'd17;
    @(posedge clk) #2;
    dif.div_in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk) #2;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_in_ready", {31'd0, dif.div_in_ready}, 32'd1);
    chk("rst_mid_quot", dif.div_quot, 32'd0);
    chk("rst_mid_rem", dif.div_rem, 32'd0);
    watch(40, seen);
    chk("rst_mid_no_result", {31'd0, seen}, 32'd0);
    @(posedge clk) #2;

    // Flush and out_ready together in DONE: result is dropped.
    dif.div_in_valid = 1'b1;
    dif.div_signed   = 1'b0;
    dif.div_src1     = 32'd77;
    dif.div_src2     = 32'd7;
    @(posedge clk) #2;
    dif.div_in_valid = 1'b0;
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (dif.div_out_valid || lat >= 100) break;
    end
    chk("flush_done_lat", 32'(lat), 32'd33);
    flush = 1'b1;
    dif.div_out_ready = 1'b1;
    @(posedge clk) #2;
    flush = 1'b0;
    dif.div_out_ready = 1'b0;
    watch(40, seen);
    chk("flush_done_no_result", {31'd0, seen}, 32'd0);
    @(posedge clk) #2;

    for (int i = 0; i < 25; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = $urandom_range(1, 15);
        3: begin a = $urandom_range(0, 200); b = 32'hFFFFFFFF - $urandom_range(0, 3); end
        default: ;
      endcase
      hold = $urandom_range(0, 3);
      do_op(s, a, b, hold, q, r, lat);
      chk("rnd_lat", 32'(lat), 32'd33);
      chk("rnd_q", q, ref_q(s, a, b));
      chk("rnd_r", r, ref_r(s, a, b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
